// File: rtl/pc_write_unit_pkg.sv
// Shared encodings for the PC write stage: next-PC sources, exception causes,
// exception-sequence states and the default handler vector addresses.
package pc_write_unit_pkg;

    typedef enum logic [1:0] {
        PC_SRC_ALU_RESULT = 2'b00,
        PC_SRC_ALU_OUT    = 2'b01,
        PC_SRC_JUMP       = 2'b10,
        PC_SRC_EPC        = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        CAUSE_OPCODE   = 2'b00,
        CAUSE_OVF      = 2'b01,
        CAUSE_DIV0     = 2'b10,
        CAUSE_RESERVED = 2'b11
    } exc_cause_e;

    typedef enum logic [1:0] {
        EXC_IDLE,
        EXC_SAVE,
        EXC_WAIT,
        EXC_LOAD
    } exc_state_e;

    localparam int unsigned DEF_VEC_OPCODE = 253;
    localparam int unsigned DEF_VEC_OVF    = 254;
    localparam int unsigned DEF_VEC_DIV0   = 255;

endpackage

// File: rtl/pc_exc_fsm.sv
// Exception sequencer: state register, handler vector latch, busy and
// memory-read request generation.
module pc_exc_fsm
    import pc_write_unit_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned VEC_OPCODE = DEF_VEC_OPCODE,
    parameter int unsigned VEC_OVF    = DEF_VEC_OVF,
    parameter int unsigned VEC_DIV0   = DEF_VEC_DIV0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exc_req,
    input  logic [1:0]       exc_cause,
    output exc_state_e       state,
    output logic             exc_busy,
    output logic             exc_mem_rd,
    output logic [WIDTH-1:0] exc_mem_addr
);

    exc_state_e       state_next;
    logic [WIDTH-1:0] vec_addr;
    logic [WIDTH-1:0] vec_sel;

    always_comb begin
        vec_sel = WIDTH'(VEC_OPCODE);
        case (exc_cause_e'(exc_cause))
            CAUSE_OVF:  vec_sel = WIDTH'(VEC_OVF);
            CAUSE_DIV0: vec_sel = WIDTH'(VEC_DIV0);
            default:    vec_sel = WIDTH'(VEC_OPCODE);
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            EXC_IDLE: if (exc_req) state_next = EXC_SAVE;
            EXC_SAVE: state_next = EXC_WAIT;
            EXC_WAIT: state_next = EXC_LOAD;
            EXC_LOAD: state_next = EXC_IDLE;
            default:  state_next = EXC_IDLE;
        endcase
    end

    // Vector is captured on acceptance so the address is already valid in SAVE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EXC_IDLE;
            vec_addr <= '0;
        end else begin
            state <= state_next;
            if (state == EXC_IDLE && exc_req)
                vec_addr <= vec_sel;
        end
    end

    assign exc_busy     = (state != EXC_IDLE);
    assign exc_mem_rd   = (state == EXC_SAVE) || (state == EXC_WAIT);
    assign exc_mem_addr = exc_mem_rd ? vec_addr : '0;

endmodule

// File: rtl/pc_write_unit.sv
// Program-counter stage: PC/EPC registers, next-PC mux and exception sequencing.
// Optional branch statistics counters enabled by PC_BRANCH_STATS_EN.
module pc_write_unit
    import pc_write_unit_pkg::*;
#(
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned       VEC_OPCODE = DEF_VEC_OPCODE,
    parameter int unsigned       VEC_OVF    = DEF_VEC_OVF,
    parameter int unsigned       VEC_DIV0   = DEF_VEC_DIV0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic             cond_in,
    input  logic [1:0]       pc_source,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [25:0]      instr_idx,
    input  logic             exc_req,
    input  logic [1:0]       exc_cause,
    input  logic [7:0]       mem_data,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] epc,
    output logic             exc_busy,
    output logic             exc_mem_rd,
    output logic [WIDTH-1:0] exc_mem_addr,
    output logic             pc_written
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [31:0]      br_taken_cnt,
    output logic [31:0]      br_not_taken_cnt
`endif
);

    exc_state_e       state;
    logic             idle;
    logic             pc_en;
    logic [WIDTH-1:0] pc_next;

    pc_exc_fsm #(
        .WIDTH      (WIDTH),
        .VEC_OPCODE (VEC_OPCODE),
        .VEC_OVF    (VEC_OVF),
        .VEC_DIV0   (VEC_DIV0)
    ) u_exc_fsm (
        .clk          (clk),
        .reset        (reset),
        .exc_req      (exc_req),
        .exc_cause    (exc_cause),
        .state        (state),
        .exc_busy     (exc_busy),
        .exc_mem_rd   (exc_mem_rd),
        .exc_mem_addr (exc_mem_addr)
    );

    assign idle  = (state == EXC_IDLE);
    // An exception request wins over any PC write in the same cycle.
    assign pc_en = idle && !exc_req && (pc_write || (pc_write_cond && cond_in));

    always_comb begin
        pc_next = alu_result;
        case (pc_src_e'(pc_source))
            PC_SRC_ALU_RESULT: pc_next = alu_result;
            PC_SRC_ALU_OUT:    pc_next = alu_out;
            PC_SRC_JUMP:       pc_next = {pc[WIDTH-1:28], instr_idx, 2'b00};
            PC_SRC_EPC:        pc_next = epc;
            default:           pc_next = alu_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            epc        <= '0;
            pc_written <= 1'b0;
        end else begin
            pc_written <= 1'b0;
            if (pc_en) begin
                pc         <= pc_next;
                pc_written <= 1'b1;
            end
            if (state == EXC_SAVE)
                epc <= pc - WIDTH'(4);
            if (state == EXC_LOAD) begin
                pc         <= {{(WIDTH-8){1'b0}}, mem_data};
                pc_written <= 1'b1;
            end
        end
    end

`ifdef PC_BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            br_taken_cnt     <= '0;
            br_not_taken_cnt <= '0;
        end else if (idle && pc_write_cond && !pc_write) begin
            if (cond_in)
                br_taken_cnt <= br_taken_cnt + 32'd1;
            else
                br_not_taken_cnt <= br_not_taken_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_write_unit.sv
// Bench for pc_write_unit: directed scenarios plus randomized cycles checked
// against a cycle-step reference model.
module tb_pc_write_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        pc_write_cond;
    logic        cond_in;
    logic [1:0]  pc_source;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic [25:0] instr_idx;
    logic        exc_req;
    logic [1:0]  exc_cause;
    logic [7:0]  mem_data;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        exc_busy;
    logic        exc_mem_rd;
    logic [31:0] exc_mem_addr;
    logic        pc_written;
`ifdef PC_BRANCH_STATS_EN
    logic [31:0] br_taken_cnt;
    logic [31:0] br_not_taken_cnt;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: step = cycles into the exception sequence (0 = idle).
    logic [31:0] m_pc, m_epc, m_vec, m_taken, m_not_taken;
    int unsigned m_step;
    logic        m_written;

    pc_write_unit #(
        .WIDTH      (32),
        .RESET_PC   (32'h0),
        .VEC_OPCODE (253),
        .VEC_OVF    (254),
        .VEC_DIV0   (255)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .cond_in       (cond_in),
        .pc_source     (pc_source),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .instr_idx     (instr_idx),
        .exc_req       (exc_req),
        .exc_cause     (exc_cause),
        .mem_data      (mem_data),
        .pc            (pc),
        .epc           (epc),
        .exc_busy      (exc_busy),
        .exc_mem_rd    (exc_mem_rd),
        .exc_mem_addr  (exc_mem_addr),
        .pc_written    (pc_written)
`ifdef PC_BRANCH_STATS_EN
        ,
        .br_taken_cnt     (br_taken_cnt),
        .br_not_taken_cnt (br_not_taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_pc = 32'h0; m_epc = 32'h0; m_step = 0; m_written = 1'b0;
            m_vec = 32'h0; m_taken = 32'h0; m_not_taken = 32'h0;
        end else if (m_step == 0) begin
            m_written = 1'b0;
            if (pc_write_cond && !pc_write) begin
                if (cond_in) m_taken++; else m_not_taken++;
            end
            if (exc_req) begin
                m_step = 1;
                m_vec  = (exc_cause == 2'd1) ? 32'd254 : (exc_cause == 2'd2) ? 32'd255 : 32'd253;
            end else if (pc_write || (pc_write_cond && cond_in)) begin
                m_written = 1'b1;
                case (pc_source)
                    2'd0: m_pc = alu_result;
                    2'd1: m_pc = alu_out;
                    2'd2: m_pc = {m_pc[31:28], instr_idx, 2'b00};
                    default: m_pc = m_epc;
                endcase
            end
        end else if (m_step == 1) begin
            m_epc = m_pc - 32'd4; m_step = 2; m_written = 1'b0;
        end else if (m_step == 2) begin
            m_step = 3; m_written = 1'b0;
        end else begin
            m_pc = {24'h0, mem_data}; m_step = 0; m_written = 1'b1;
        end
    endtask

    task automatic tick();
        logic rd_exp;
        model_step();
        @(posedge clk);
        #1;
        rd_exp = (m_step == 1) || (m_step == 2);
        check("pc", pc, m_pc);
        check("epc", epc, m_epc);
        check("exc_busy", {31'h0, exc_busy}, {31'h0, m_step != 0});
        check("exc_mem_rd", {31'h0, exc_mem_rd}, {31'h0, rd_exp});
        check("exc_mem_addr", exc_mem_addr, rd_exp ? m_vec : 32'h0);
        check("pc_written", {31'h0, pc_written}, {31'h0, m_written});
`ifdef PC_BRANCH_STATS_EN
        check("br_taken_cnt", br_taken_cnt, m_taken);
        check("br_not_taken_cnt", br_not_taken_cnt, m_not_taken);
`endif
    endtask

    task automatic idle_inputs();
        pc_write = 1'b0; pc_write_cond = 1'b0; cond_in = 1'b0; exc_req = 1'b0;
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_write = 1'b1; pc_source = 2'b00; alu_result = v;
        tick();
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1; idle_inputs(); pc_source = 2'b00; alu_result = '0; alu_out = '0;
        instr_idx = '0; exc_cause = 2'b00; mem_data = 8'h80;
        tick(); tick();
        check("rst_pc", pc, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_busy", {31'h0, exc_busy}, 32'h0);
        reset = 1'b0;

        load_pc(32'h4);
        check("dir_pc4", pc, 32'h4);
        check("dir_written", {31'h0, pc_written}, 32'h1);
        tick();
        check("dir_written_clr", {31'h0, pc_written}, 32'h0);

        pc_write_cond = 1'b1; pc_source = 2'b01; alu_out = 32'h40; cond_in = 1'b0;
        tick();
        check("br_not_taken_pc", pc, 32'h4);
        cond_in = 1'b1;
        tick();
        check("br_taken_pc", pc, 32'h40);
        idle_inputs();
`ifdef PC_BRANCH_STATS_EN
        check("dir_taken_cnt", br_taken_cnt, 32'd1);
        check("dir_not_taken_cnt", br_not_taken_cnt, 32'd1);
`endif

        load_pc(32'h1000_0008);
        pc_write = 1'b1; pc_source = 2'b10; instr_idx = 26'h10;
        tick();
        idle_inputs();
        check("jump_pc", pc, 32'h1000_0040);

        load_pc(32'h24);
        exc_req = 1'b1; exc_cause = 2'b01; mem_data = 8'h80;
        tick();
        check("ovf_addr_1", exc_mem_addr, 32'd254);
        check("ovf_rd_1", {31'h0, exc_mem_rd}, 32'h1);
        exc_req = 1'b0; pc_write = 1'b1; alu_result = 32'hDEAD_0000;
        tick();
        check("ovf_addr_2", exc_mem_addr, 32'd254);
        check("ovf_epc", epc, 32'h20);
        tick();
        check("ovf_rd_3", {31'h0, exc_mem_rd}, 32'h0);
        check("ovf_pc_hold", pc, 32'h24);
        tick();
        idle_inputs();
        check("ovf_handler_pc", pc, 32'h80);
        check("ovf_busy_clr", {31'h0, exc_busy}, 32'h0);

        pc_write = 1'b1; pc_source = 2'b11;
        tick();
        idle_inputs();
        check("eret_pc", pc, 32'h20);

        exc_req = 1'b1; pc_write = 1'b1; pc_source = 2'b00; alu_result = 32'h1234; exc_cause = 2'b10;
        tick();
        idle_inputs();
        check("simul_pc", pc, 32'h20);
        check("simul_busy", {31'h0, exc_busy}, 32'h1);
        check("div0_addr", exc_mem_addr, 32'd255);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_pc", pc, 32'h0);
        check("midreset_epc", epc, 32'h0);
        check("midreset_busy", {31'h0, exc_busy}, 32'h0);

        exc_req = 1'b1; exc_cause = 2'b11;
        tick();
        exc_req = 1'b0;
        check("rsvd_addr", exc_mem_addr, 32'd253);
        tick();
        check("wrap_epc", epc, 32'hFFFF_FFFC);
        tick(); tick();

        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            pc_write      = ($urandom_range(0, 3) == 0);
            pc_write_cond = ($urandom_range(0, 2) == 0);
            cond_in       = $urandom_range(0, 1) == 1;
            pc_source     = 2'($urandom_range(0, 3));
            alu_result    = $urandom;
            alu_out       = $urandom;
            instr_idx     = 26'($urandom);
            exc_req       = ($urandom_range(0, 7) == 0);
            exc_cause     = 2'($urandom_range(0, 3));
            mem_data      = 8'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
